// File: rtl/cpu_mem_port.sv
// Memory access unit: turns controller read strobes into a req/ack bus read,
// stalls the controller during wait states and latches a sticky timeout error.
module cpu_mem_port #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              saveOpcode,
  input  logic              saveMem,
  output logic              stall,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] memValue,
  output logic              busReq,
  output logic [ADDR_W-1:0] busAddr,
  input  logic              busAck,
  input  logic [DATA_W-1:0] busRdata,
  output logic              busError
);

  localparam int unsigned     CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERROR} state_t;

  state_t          state, next;
  logic [CW-1:0]   cnt;
  logic            sel_op, sel_mem;
  logic            start;
  logic            ack_hit;

  assign start   = (state == IDLE) && (saveOpcode || saveMem);
  assign ack_hit = (state == REQ) && busAck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // Ack wins over the timeout check, so an ack in the last allowed cycle completes.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = REQ;
      REQ: begin
        if (busAck)           next = DONE;
        else if (cnt == LAST) next = ERROR;
      end
      DONE:    next = IDLE;
      ERROR:   next = ERROR;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    busError = 1'b0;
    case (state)
      IDLE:  stall = start && rst;
      REQ:   stall = 1'b1;
      ERROR: begin
        stall    = 1'b1;
        busError = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busReq   <= 1'b0;
      busAddr  <= '0;
      cnt      <= '0;
      sel_op   <= 1'b0;
      sel_mem  <= 1'b0;
      opcode   <= '0;
      memValue <= '0;
    end else begin
      busReq <= (next == REQ);
      if (start) begin
        busAddr <= addr;
        sel_op  <= saveOpcode;
        sel_mem <= saveMem;
        cnt     <= '0;
      end
      if (state == REQ && !busAck) cnt <= cnt + CW'(1);
      if (ack_hit && sel_op)  opcode   <= busRdata;
      if (ack_hit && sel_mem) memValue <= busRdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_port.sv
// Self-checking bench for cpu_mem_port: directed vector table, randomized
// transactions against a transaction-level model, timeout and reset corners.
module tb_cpu_mem_port;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          saveOpcode, saveMem;
  logic          stall;
  logic [DW-1:0] opcode, memValue;
  logic          busReq;
  logic [AW-1:0] busAddr;
  logic          busAck;
  logic [DW-1:0] busRdata;
  logic          busError;

  cpu_mem_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .saveOpcode(saveOpcode), .saveMem(saveMem),
    .stall(stall), .opcode(opcode), .memValue(memValue), .busReq(busReq),
    .busAddr(busAddr), .busAck(busAck), .busRdata(busRdata), .busError(busError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: the registers as the controller expects to see them.
  logic [DW-1:0] m_op  = '0;
  logic [DW-1:0] m_mem = '0;

  typedef struct {
    logic          op;
    logic          mem;
    logic [AW-1:0] a;
    int unsigned   waits;
    logic [DW-1:0] d;
    logic [DW-1:0] eop;
    logic [DW-1:0] emem;
    int unsigned   gap;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic op, input logic mem, input logic [AW-1:0] a,
                       input logic ack, input logic [DW-1:0] d);
    @(negedge clk);
    saveOpcode = op;
    saveMem    = mem;
    addr       = a;
    busAck     = ack;
    busRdata   = d;
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".opcode"}, 32'(opcode), 32'(m_op));
    chk({tag, ".memValue"}, 32'(memValue), 32'(m_mem));
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 1'b0, 16'($urandom), ack, 16'($urandom));
    chk("idle.stall", 32'(stall), 0);
    chk("idle.busReq", 32'(busReq), 0);
    chk("idle.busError", 32'(busError), 0);
    chk_regs("idle");
  endtask

  // Strobes stay high through DONE, as a stalled controller would hold them.
  task automatic do_access(input logic op, input logic mem, input logic [AW-1:0] a,
                           input int unsigned waits, input logic [DW-1:0] d);
    drive(op, mem, a, 1'b0, 16'($urandom));
    chk("strobe.stall", 32'(stall), 1);
    chk("strobe.busReq", 32'(busReq), 0);
    for (int unsigned k = 0; k <= waits; k++) begin
      drive(op, mem, 16'($urandom), (k == waits), (k == waits) ? d : 16'($urandom));
      chk("req.stall", 32'(stall), 1);
      chk("req.busReq", 32'(busReq), 1);
      chk("req.busAddr", 32'(busAddr), 32'(a));
      chk("req.busError", 32'(busError), 0);
      chk_regs("req");
    end
    if (op)  m_op  = d;
    if (mem) m_mem = d;
    drive(op, mem, 16'($urandom), 1'($urandom), 16'($urandom));
    chk("done.stall", 32'(stall), 0);
    chk("done.busReq", 32'(busReq), 0);
    chk_regs("done");
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 16'h0010, 0, 16'h4A21, 16'h4A21, 16'h0000, 1};
    vt[1] = '{1'b0, 1'b1, 16'h0123, 3, 16'hBEEF, 16'h4A21, 16'hBEEF, 1};
    vt[2] = '{1'b1, 1'b0, 16'h0200, 0, 16'h4000, 16'h4000, 16'hBEEF, 0};
    vt[3] = '{1'b0, 1'b1, 16'h0201, 1, 16'h0005, 16'h4000, 16'h0005, 2};
    vt[4] = '{1'b1, 1'b1, 16'h0300, 2, 16'h7E57, 16'h7E57, 16'h7E57, 1};
    vt[5] = '{1'b1, 1'b0, 16'hFFFF, 3, 16'h0000, 16'h0000, 16'h7E57, 0};
    vt[6] = '{1'b0, 1'b1, 16'h0000, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1};

    rst = 1'b0; addr = '0; saveOpcode = 0; saveMem = 0; busAck = 0; busRdata = '0;

    // Reset held with random inputs: nothing is honoured.
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      chk("rst.stall", 32'(stall), 0);
      chk("rst.busReq", 32'(busReq), 0);
      chk("rst.busError", 32'(busError), 0);
      chk("rst.busAddr", 32'(busAddr), 0);
      chk_regs("rst");
    end
    saveOpcode = 0; saveMem = 0;
    rst = 1'b1;
    idle(1'b1);  // spurious ack in IDLE
    idle(1'b0);

    for (int i = 0; i < 7; i++) begin
      do_access(vt[i].op, vt[i].mem, vt[i].a, vt[i].waits, vt[i].d);
      chk("vec.opcode", 32'(opcode), 32'(vt[i].eop));
      chk("vec.memValue", 32'(memValue), 32'(vt[i].emem));
      for (int unsigned g = 0; g < vt[i].gap; g++) idle(1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      sel = $urandom_range(1, 3);
      do_access(sel[1], sel[0], 16'($urandom), $urandom_range(0, TO - 1), 16'($urandom));
      for (int unsigned g = $urandom_range(0, 2); g > 0; g--) idle(1'($urandom));
    end
    idle(1'b0);

    // Timeout: busReq for exactly TO cycles, then sticky error.
    drive(1'b1, 1'b0, 16'h0AAA, 1'b0, 16'h2222);
    chk("to.strobe.stall", 32'(stall), 1);
    for (int unsigned k = 0; k < TO; k++) begin
      drive(1'b1, 1'b0, 16'($urandom), 1'b0, 16'($urandom));
      chk("to.req.busReq", 32'(busReq), 1);
      chk("to.req.stall", 32'(stall), 1);
      chk("to.req.busAddr", 32'(busAddr), 32'h0AAA);
    end
    drive(1'b1, 1'b0, 16'($urandom), 1'b0, 16'($urandom));
    chk("to.err.busReq", 32'(busReq), 0);
    chk("to.err.stall", 32'(stall), 1);
    chk("to.err.busError", 32'(busError), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 16'($urandom), 1'b1, 16'h1111);
      chk("to.ack.busError", 32'(busError), 1);
      chk("to.ack.stall", 32'(stall), 1);
      chk("to.ack.busReq", 32'(busReq), 0);
      chk_regs("to.ack");
    end
    rst = 1'b0;
    #1;
    m_op = '0; m_mem = '0;
    chk("to.rst.busError", 32'(busError), 0);
    chk("to.rst.stall", 32'(stall), 0);
    chk_regs("to.rst");
    @(negedge clk);
    rst = 1'b1;
    busAck = 1'b0;
    idle(1'b0);

    // Reset during the 2nd wait cycle of a fetch.
    drive(1'b1, 1'b0, 16'h0555, 1'b0, 16'h3333);
    chk("mid.strobe.stall", 32'(stall), 1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 16'($urandom), 1'b0, 16'($urandom));
      chk("mid.req.busReq", 32'(busReq), 1);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid.rst.busReq", 32'(busReq), 0);
    chk("mid.rst.stall", 32'(stall), 0);
    chk("mid.rst.opcode", 32'(opcode), 0);
    saveOpcode = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    do_access(1'b1, 1'b0, 16'h0556, 1, 16'h1234);
    chk("mid.after.opcode", 32'(opcode), 32'h1234);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
